// File: rtl/rib_arbiter2.sv
// Two-master to one-slave RIB arbiter: round-robin with request lock, in-order ID FIFO routes responses.
// Latency: zero cycles; request and response paths are combinational pass-throughs.
// Backpressure: gnt follows slave gnt; requests stall while DEPTH responses are pending; o_s_rdy follows the head master's rdy.
module rib_arbiter2 #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [AW-1:0]     i_m0_addr,
    input  logic              i_m0_wrcs,
    input  logic [DW/8-1:0]   i_m0_mask,
    input  logic [DW-1:0]     i_m0_wdata,
    input  logic              i_m0_req,
    output logic              o_m0_gnt,
    output logic [DW-1:0]     o_m0_rdata,
    output logic              o_m0_rsp,
    input  logic              i_m0_rdy,
    input  logic [AW-1:0]     i_m1_addr,
    input  logic              i_m1_wrcs,
    input  logic [DW/8-1:0]   i_m1_mask,
    input  logic [DW-1:0]     i_m1_wdata,
    input  logic              i_m1_req,
    output logic              o_m1_gnt,
    output logic [DW-1:0]     o_m1_rdata,
    output logic              o_m1_rsp,
    input  logic              i_m1_rdy,
    output logic [AW-1:0]     o_s_addr,
    output logic              o_s_wrcs,
    output logic [DW/8-1:0]   o_s_mask,
    output logic [DW-1:0]     o_s_wdata,
    output logic              o_s_req,
    input  logic              i_s_gnt,
    input  logic [DW-1:0]     i_s_rdata,
    input  logic              i_s_rsp,
    output logic              o_s_rdy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Arbitration state: who has priority, and whether a stalled request pins the selection.
    logic rr_ptr;
    logic lock;
    logic lock_id;

    // ID FIFO: one bit per outstanding transaction naming the issuing master.
    logic [DEPTH-1:0] fifo_mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    logic sel;
    logic sel_req;
    logic full;
    logic empty;
    logic s_req;
    logic push;
    logic head;
    logic head_rdy;
    logic s_rdy;
    logic pop;

    // Pick the master to present: a stalled request keeps its slot, otherwise round-robin among requesters.
    always_comb begin
        sel = rr_ptr;
        if (lock) begin
            sel = lock_id;
        end else if (i_m0_req && i_m1_req) begin
            sel = rr_ptr;
        end else if (i_m0_req) begin
            sel = 1'b0;
        end else if (i_m1_req) begin
            sel = 1'b1;
        end
    end

    // Handshake qualifiers; reset forces every output low, so the gating lives here.
    always_comb begin
        full     = (count == CW'(DEPTH));
        empty    = (count == '0);
        sel_req  = sel ? i_m1_req : i_m0_req;
        s_req    = sel_req & ~full & ~i_reset;
        push     = s_req & i_s_gnt;
        head     = fifo_mem[rd_ptr];
        head_rdy = head ? i_m1_rdy : i_m0_rdy;
        s_rdy    = ~empty & head_rdy & ~i_reset;
        pop      = i_s_rsp & s_rdy;
    end

    // Drive slave request fields from the selected master and route responses to the FIFO head.
    always_comb begin
        o_s_req    = s_req;
        o_s_addr   = '0;
        o_s_wrcs   = 1'b0;
        o_s_mask   = '0;
        o_s_wdata  = '0;
        if (s_req) begin
            o_s_addr  = sel ? i_m1_addr  : i_m0_addr;
            o_s_wrcs  = sel ? i_m1_wrcs  : i_m0_wrcs;
            o_s_mask  = sel ? i_m1_mask  : i_m0_mask;
            o_s_wdata = sel ? i_m1_wdata : i_m0_wdata;
        end
        o_m0_gnt   = push & ~sel;
        o_m1_gnt   = push & sel;
        o_s_rdy    = s_rdy;
        o_m0_rsp   = ~i_reset & ~empty & ~head & i_s_rsp;
        o_m1_rsp   = ~i_reset & ~empty & head & i_s_rsp;
        o_m0_rdata = i_reset ? '0 : i_s_rdata;
        o_m1_rdata = i_reset ? '0 : i_s_rdata;
    end

    // Round-robin pointer and lock: lock while the slave stalls, release and rotate on acceptance.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rr_ptr  <= 1'b0;
            lock    <= 1'b0;
            lock_id <= 1'b0;
        end else if (push) begin
            rr_ptr <= ~sel;
            lock   <= 1'b0;
        end else if (s_req) begin
            lock    <= 1'b1;
            lock_id <= sel;
        end
    end

    // ID FIFO: record the granted master on push, retire the head on response handshake.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            fifo_mem <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= sel;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_rib_arbiter2.sv
// Bench for rib_arbiter2: directed cycle scenarios with a response scoreboard.
// Inputs change 1 time unit after the rising edge; outputs are checked mid-cycle.
// Expected responses are queued at grant time and retired when the DUT hands one to a master.
module tb_rib_arbiter2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_addr, m1_addr;
    logic        m0_wrcs, m1_wrcs;
    logic [3:0]  m0_mask, m1_mask;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_req, m1_req;
    logic        m0_gnt, m1_gnt;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_rsp, m1_rsp;
    logic        m0_rdy, m1_rdy;
    logic [31:0] s_addr;
    logic        s_wrcs;
    logic [3:0]  s_mask;
    logic [31:0] s_wdata;
    logic        s_req;
    logic        s_gnt;
    logic [31:0] s_rdata;
    logic        s_rsp;
    logic        s_rdy;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
    } sb_t;

    sb_t exp_q[$];
    sb_t mon_item;
    int  n_tests = 0;
    int  n_fail  = 0;

    rib_arbiter2 #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_m0_addr(m0_addr), .i_m0_wrcs(m0_wrcs), .i_m0_mask(m0_mask), .i_m0_wdata(m0_wdata),
        .i_m0_req(m0_req), .o_m0_gnt(m0_gnt), .o_m0_rdata(m0_rdata), .o_m0_rsp(m0_rsp), .i_m0_rdy(m0_rdy),
        .i_m1_addr(m1_addr), .i_m1_wrcs(m1_wrcs), .i_m1_mask(m1_mask), .i_m1_wdata(m1_wdata),
        .i_m1_req(m1_req), .o_m1_gnt(m1_gnt), .o_m1_rdata(m1_rdata), .o_m1_rsp(m1_rsp), .i_m1_rdy(m1_rdy),
        .o_s_addr(s_addr), .o_s_wrcs(s_wrcs), .o_s_mask(s_mask), .o_s_wdata(s_wdata), .o_s_req(s_req),
        .i_s_gnt(s_gnt), .i_s_rdata(s_rdata), .i_s_rsp(s_rsp), .o_s_rdy(s_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        m0_req = 1'b0; m1_req = 1'b0; s_gnt = 1'b0; s_rsp = 1'b0; s_rdata = '0;
        m0_addr = '0; m1_addr = '0; m0_wrcs = 1'b0; m1_wrcs = 1'b0;
        m0_mask = '0; m1_mask = '0; m0_wdata = '0; m1_wdata = '0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        idle_inputs();
        #2 rst = 1'b1;
        exp_q.delete();
        #2 rst = 1'b0;
    endtask

    // Response monitor: every response handshake must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (m0_rsp && m1_rsp) begin
                chk("rsp_both_masters", {63'd0, m0_rsp & m1_rsp}, 64'd0);
            end else if ((m0_rsp && m0_rdy) || (m1_rsp && m1_rdy)) begin
                chk("sb_nonempty", {63'd0, exp_q.size() != 0}, 64'd1);
                if (exp_q.size() != 0) begin
                    mon_item = exp_q.pop_front();
                    chk("sb_id", {63'd0, m1_rsp}, {63'd0, mon_item.id});
                    chk("sb_data", m1_rsp ? m1_rdata : m0_rdata, mon_item.data);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        m0_rdy = 1'b1; m1_rdy = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        // Reset holds all outputs low even with active inputs
        m0_req = 1'b1; m0_addr = 32'h1234; s_rsp = 1'b1; s_gnt = 1'b1;
        settle();
        chk("rst_sreq", s_req, 0);
        chk("rst_saddr", s_addr, 0);
        chk("rst_m0gnt", m0_gnt, 0);
        chk("rst_m0rsp", m0_rsp, 0);
        chk("rst_srdy", s_rdy, 0);
        chk("rst_count", dut.count, 0);
        idle_inputs();
        rst = 1'b0;
        tick();
        settle();
        chk("idle_sreq", s_req, 0);
        chk("idle_saddr", s_addr, 0);
        chk("idle_gnt", {m0_gnt, m1_gnt}, 0);
        chk("idle_rsp", {m0_rsp, m1_rsp}, 0);
        chk("idle_srdy", s_rdy, 0);

        // Single master read
        tick();
        m0_addr = 32'h1000_0004; m0_req = 1'b1; s_gnt = 1'b1;
        settle();
        chk("t1_sreq", s_req, 1);
        chk("t1_saddr", s_addr, 32'h1000_0004);
        chk("t1_m0gnt", m0_gnt, 1);
        chk("t1_m1gnt", m1_gnt, 0);
        exp_q.push_back({1'b0, 32'hDEAD_BEEF});
        tick();
        m0_req = 1'b0; s_gnt = 1'b0;
        settle();
        chk("t1_gnt_once", m0_gnt, 0);
        chk("t1_count1", dut.count, 1);
        tick();
        s_rsp = 1'b1; s_rdata = 32'hDEAD_BEEF;
        settle();
        chk("t1_m0rsp", m0_rsp, 1);
        chk("t1_m1rsp", m1_rsp, 0);
        chk("t1_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("t1_srdy", s_rdy, 1);
        tick();
        s_rsp = 1'b0; s_rdata = '0;
        settle();
        chk("t1_count0", dut.count, 0);

        // Contention: alternating grants from reset, responses in grant order
        do_reset();
        for (int k = 0; k < 4; k++) begin
            tick();
            m0_req = 1'b1; m1_req = 1'b1; s_gnt = 1'b1;
            m0_addr = 32'h100 + k; m1_addr = 32'h200 + k;
            settle();
            chk("t2_m0gnt", m0_gnt, (k % 2) == 0);
            chk("t2_m1gnt", m1_gnt, (k % 2) == 1);
            chk("t2_saddr", s_addr, (k % 2) ? 32'h200 + k : 32'h100 + k);
            exp_q.push_back({(k % 2) == 1, 32'hC0DE_0000 + k});
        end
        tick();
        m0_req = 1'b0; m1_req = 1'b0; s_gnt = 1'b0;
        settle();
        chk("t2_count4", dut.count, 4);
        for (int k = 0; k < 4; k++) begin
            tick();
            s_rsp = 1'b1; s_rdata = 32'hC0DE_0000 + k;
            settle();
            chk("t2_route_m1", m1_rsp, (k % 2) == 1);
            chk("t2_route_m0", m0_rsp, (k % 2) == 0);
        end
        tick();
        s_rsp = 1'b0;
        settle();
        chk("t2_count0", dut.count, 0);

        // Lock: slave stalls, selection holds
        do_reset();
        tick();
        m0_req = 1'b1; m1_req = 1'b1; m0_addr = 32'h3000; m1_addr = 32'h3100; s_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            settle();
            chk("t3_hold_addr", s_addr, 32'h3000);
            chk("t3_hold_gnt", {m0_gnt, m1_gnt}, 0);
        end
        tick();
        s_gnt = 1'b1;
        settle();
        chk("t3_m0gnt", m0_gnt, 1);
        exp_q.push_back({1'b0, 32'h3333_0000});
        tick();
        m0_addr = 32'h3004;
        settle();
        chk("t3_next_m1", m1_gnt, 1);
        chk("t3_next_m0", m0_gnt, 0);
        chk("t3_next_addr", s_addr, 32'h3100);
        exp_q.push_back({1'b1, 32'h3333_0001});
        tick();
        m0_req = 1'b0; s_gnt = 1'b0; m1_addr = 32'h3200;
        settle();
        chk("t3_single_addr", s_addr, 32'h3200);
        tick();
        m0_req = 1'b1; m0_addr = 32'h3008;
        settle();
        chk("t3_lock_m1", s_addr, 32'h3200);
        chk("t3_lock_m0gnt", m0_gnt, 0);
        tick();
        s_gnt = 1'b1;
        settle();
        chk("t3_lock_grant", m1_gnt, 1);
        exp_q.push_back({1'b1, 32'h3333_0002});
        tick();
        m0_req = 1'b0; m1_req = 1'b0; s_gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            s_rsp = 1'b1; s_rdata = 32'h3333_0000 + k;
            settle();
            chk("t3_route", m1_rsp, k != 0);
        end
        tick();
        s_rsp = 1'b0;

        // Full: four writes accepted, fifth waits for a pop
        do_reset();
        for (int k = 0; k < 5; k++) begin
            tick();
            m1_req = 1'b1; m1_wrcs = 1'b1; m1_mask = 4'hF; s_gnt = 1'b1;
            m1_addr = 32'h400 + k; m1_wdata = 32'hA000 + k;
            settle();
            if (k < 4) begin
                chk("t4_m1gnt", m1_gnt, 1);
                exp_q.push_back({1'b1, 32'h4444_0000 + k});
            end else begin
                chk("t4_full_sreq", s_req, 0);
                chk("t4_full_gnt", m1_gnt, 0);
                chk("t4_count4", dut.count, 4);
            end
            if (k == 0) begin
                chk("t4_wrcs", s_wrcs, 1);
                chk("t4_mask", s_mask, 4'hF);
                chk("t4_wdata", s_wdata, 32'hA000);
            end
        end
        tick();
        s_rsp = 1'b1; s_rdata = 32'h4444_0000;
        settle();
        chk("t4_pop_sreq", s_req, 0);
        chk("t4_pop_rsp", m1_rsp, 1);
        tick();
        s_rsp = 1'b0;
        settle();
        chk("t4_resume_sreq", s_req, 1);
        chk("t4_resume_gnt", m1_gnt, 1);
        chk("t4_resume_addr", s_addr, 32'h404);
        exp_q.push_back({1'b1, 32'h4444_0004});
        tick();
        m1_req = 1'b0; s_gnt = 1'b0;
        for (int k = 1; k < 5; k++) begin
            tick();
            s_rsp = 1'b1; s_rdata = 32'h4444_0000 + k;
            settle();
            chk("t4_drain", m1_rsp, 1);
        end
        tick();
        s_rsp = 1'b0;
        settle();
        chk("t4_count0", dut.count, 0);

        // Backpressure, simultaneous push/pop, stray response
        do_reset();
        tick();
        m0_req = 1'b1; m0_addr = 32'h500; s_gnt = 1'b1;
        settle();
        chk("t5_m0gnt", m0_gnt, 1);
        exp_q.push_back({1'b0, 32'h5555_0000});
        tick();
        m0_req = 1'b0; s_gnt = 1'b0; m0_rdy = 1'b0; s_rsp = 1'b1; s_rdata = 32'h5555_0000;
        for (int i = 0; i < 2; i++) begin
            if (i > 0) tick();
            settle();
            chk("t5_bp_srdy", s_rdy, 0);
            chk("t5_bp_rsp", m0_rsp, 1);
            chk("t5_bp_count", dut.count, 1);
        end
        tick();
        m0_rdy = 1'b1; m1_req = 1'b1; m1_addr = 32'h510; s_gnt = 1'b1;
        settle();
        chk("t5_pp_srdy", s_rdy, 1);
        chk("t5_pp_gnt", m1_gnt, 1);
        exp_q.push_back({1'b1, 32'h5555_0001});
        tick();
        m1_req = 1'b0; s_gnt = 1'b0; s_rsp = 1'b0;
        settle();
        chk("t5_pp_count", dut.count, 1);
        tick();
        s_rsp = 1'b1; s_rdata = 32'h5555_0001;
        settle();
        chk("t5_m1rsp", m1_rsp, 1);
        chk("t5_m0rsp", m0_rsp, 0);
        tick();
        s_rsp = 1'b1; s_rdata = 32'h0BAD;
        settle();
        chk("t5_stray_rsp", {m0_rsp, m1_rsp}, 0);
        chk("t5_stray_srdy", s_rdy, 0);
        tick();
        s_rsp = 1'b0;
        settle();
        chk("t5_stray_count", dut.count, 0);

        // Asynchronous reset with two transactions outstanding
        do_reset();
        tick();
        m0_req = 1'b1; m1_req = 1'b1; m0_addr = 32'h600; m1_addr = 32'h601; s_gnt = 1'b1;
        exp_q.push_back({1'b0, 32'h6666_00AA});
        tick();
        exp_q.push_back({1'b1, 32'h6666_00BB});
        settle();
        chk("t6_pre_m1gnt", m1_gnt, 1);
        tick();
        m1_req = 1'b0; m0_addr = 32'h604; s_gnt = 1'b0; s_rsp = 1'b1; s_rdata = 32'h6666_00AA;
        #1 rst = 1'b1;
        exp_q.delete();
        #1;
        chk("t6_rst_sreq", s_req, 0);
        chk("t6_rst_saddr", s_addr, 0);
        chk("t6_rst_rsp", {m0_rsp, m1_rsp}, 0);
        chk("t6_rst_srdy", s_rdy, 0);
        chk("t6_rst_count", dut.count, 0);
        idle_inputs();
        #1 rst = 1'b0;
        tick();
        m1_req = 1'b1; m1_addr = 32'h610; s_gnt = 1'b1;
        settle();
        chk("t6_post_gnt", m1_gnt, 1);
        chk("t6_post_addr", s_addr, 32'h610);
        exp_q.push_back({1'b1, 32'h6666_0000});
        tick();
        m1_req = 1'b0; s_gnt = 1'b0; s_rsp = 1'b1; s_rdata = 32'h6666_0000;
        settle();
        chk("t6_post_rsp", m1_rsp, 1);
        tick();
        s_rsp = 1'b0;
        settle();
        chk("t6_count0", dut.count, 0);

        tick();
        chk("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rib_arbiter2.md
Name: rib_arbiter2

Overview:
Two-master, one-slave arbiter for the RIB bus. It lets the core's peripheral port (master 0) and a second master (master 1, debug/DMA) share the single PERIPH_TOP slave port. Arbitration is round-robin with a request lock. An in-order ID FIFO routes each response back to the master that issued the request. It sits between CORE_TOP ribp, the second master and PERIPH_TOP ribm.

Parameters:
DEPTH, 4, max outstanding (granted, response-pending) transactions; power of 2, >=2
AW, 32, address width
DW, 32, data width (mask width = DW/8)

Ports:
i_clk  input  1  clock, rising edge
i_reset  input  1  asynchronous, active-high reset
i_m0_addr / i_m1_addr  input  AW  master request address
i_m0_wrcs / i_m1_wrcs  input  1  1 = write, 0 = read
i_m0_mask / i_m1_mask  input  DW/8  byte write mask
i_m0_wdata / i_m1_wdata  input  DW  write data
i_m0_req / i_m1_req  input  1  master request valid
o_m0_gnt / o_m1_gnt  output  1  request accepted
o_m0_rdata / o_m1_rdata  output  DW  response data
o_m0_rsp / o_m1_rsp  output  1  response valid
i_m0_rdy / i_m1_rdy  input  1  master ready for response
o_s_addr, o_s_wrcs, o_s_mask, o_s_wdata  output  AW/1/DW/8/DW  muxed request fields to slave
o_s_req  output  1  request to slave
i_s_gnt  input  1  slave accepts request
i_s_rdata  input  DW  slave response data
i_s_rsp  input  1  slave response valid
o_s_rdy  output  1  ready for slave response

Behaviour:
- Handshakes: request transfers on req&gnt in the same cycle. Response transfers on rsp&rdy in the same cycle. Masters hold req and all fields stable until gnt.
- State: rr_ptr (1b, the master with priority), lock (1b), lock_id (1b), ID FIFO (DEPTH x 1b, wr/rd pointers, count 0..DEPTH).
- Reset (async, i_reset=1): rr_ptr=0, lock=0, FIFO empty, count=0. All outputs 0 while in reset. Out of reset with idle inputs, all outputs are 0.
- Selection (combinational): if lock=1, sel=lock_id. Else, if both masters request, sel=rr_ptr. Else sel is the single requester. Else sel=rr_ptr.
- full = (count==DEPTH). o_s_req = req[sel] & ~full. Request fields are muxed from sel.
- o_mX_gnt = i_s_gnt & o_s_req & (sel==X). The other master's gnt is 0.
- Lock: set when o_s_req=1 and i_s_gnt=0 (lock_id<=sel). Clear on the handshake. Selection never switches while a request is pending at the slave.
- On handshake: push sel into the FIFO, set rr_ptr<=~sel, clear lock.
- Response routing: head = FIFO[rd_ptr].
  - When FIFO is non-empty: o_m[head]_rsp = i_s_rsp, o_s_rdy = i_m[head]_rdy, and the other master's rsp is 0.
  - o_m0_rdata = o_m1_rdata = i_s_rdata, qualified only by rsp.
  - Pop on i_s_rsp & o_s_rdy.
- Empty FIFO: o_s_rdy=0 and both o_mX_rsp=0. A stray i_s_rsp is ignored.
- Full: o_s_req=0 even if a pop happens the same cycle. Requests resume the cycle after count<DEPTH.
- Simultaneous push and pop when not full: count unchanged, both pointers advance (mod DEPTH, wrap-around).
- Latency: zero-cycle combinational pass-through on both phases. No added pipeline stage.
- Reset mid-transaction flushes the FIFO and lock. Any in-flight responses are dropped.

Test Plan:
- Single master: m0 reads addr 0x1000_0004, slave gnt same cycle, rsp 2 cycles later with rdata 0xDEAD_BEEF, rdy=1 -> o_m0_gnt=1 for 1 cycle, o_m0_rsp=1 with 0xDEAD_BEEF, o_m1_rsp=0, count returns 0.
- Contention: m0 and m1 both request for 4 cycles, slave always gnt -> grants alternate m0,m1,m0,m1 from reset. Responses route in the same order.
- Lock: both request, slave withholds gnt 3 cycles -> o_s_addr stays m0's addr all 3 cycles. The 4th cycle grants m0, and m1 is selected next.
- Full: DEPTH=4, m1 issues 5 writes with slave rsp held low -> 4 grants, then o_s_req=0. One rsp&rdy -> 5th request granted the following cycle.
- Backpressure and empty: head=m0, i_m0_rdy=0 for 2 cycles -> o_s_rdy=0, no pop. Stray i_s_rsp with FIFO empty -> no mX_rsp, count stays 0.
- Async reset asserted with 2 outstanding -> outputs 0 immediately, count=0. After release, a new m1 request is granted normally.
